weight_update_sequencer: RTL

Single-clock controller sitting between the MAC unit, the plasticity engine and one layer's dual-port weight memory. It arbitrates the memory's read port between MAC forward-pass reads and its own update reads. It also sequences a per-neuron read-modify-write sweep: read each old weight, add a signed Q16.16 delta streamed from the plasticity engine with saturation, and write the result through the memory's write port.

---
 rtl/weight_update_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/weight_update_sequencer.sv
// Weight-memory sequencer: MAC read arbitration plus per-neuron
// saturating read-modify-write sweep driven by a plasticity delta stream.
module weight_update_sequencer #(
    parameter int NUM_NEURONS = 256,
    parameter int INPUT_SIZE  = 784,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = NUM_NEURONS * INPUT_SIZE,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int NIDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mac_req,
    input  logic [ADDR_W-1:0]     mac_addr,
    output logic [DATA_WIDTH-1:0] mac_rdata,
    output logic                  mac_rvalid,
    input  logic                  upd_start,
    input  logic [NIDX_W-1:0]     upd_neuron,
    output logic                  upd_busy,
    output logic                  upd_done,
    output logic                  upd_sat,
    input  logic                  delta_valid,
    output logic                  delta_ready,
    input  logic [DATA_WIDTH-1:0] delta_data,
    output logic                  bram_en_a,
    output logic [ADDR_W-1:0]     bram_addr_a,
    input  logic [DATA_WIDTH-1:0] bram_rdata_a,
    output logic                  bram_en_b,
    output logic                  bram_we_b,
    output logic [ADDR_W-1:0]     bram_addr_b,
    output logic [DATA_WIDTH-1:0] bram_wdata_b
);

    localparam int IDX_W = $clog2(INPUT_SIZE + 1);

    typedef enum logic [2:0] {IDLE, RD, CAP, DELTA, FIN} state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_W-1:0]     base;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] old;
    logic [ADDR_W-1:0]     cur_addr;
    logic                  start_ok;
    logic                  hs;
    logic                  last;
    logic [DATA_WIDTH:0]   sum;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] sum_sat;

    assign mac_rdata = bram_rdata_a;
    assign bram_we_b = bram_en_b;

    assign start_ok = upd_start &&
        ({1'b0, upd_neuron} < (NIDX_W + 1)'(NUM_NEURONS));
    assign hs       = (state == DELTA) && delta_valid;
    assign last     = idx == IDX_W'(INPUT_SIZE - 1);
    assign cur_addr = base + ADDR_W'(idx);

    // 33-bit sum: overflow shows as disagreement of the top two bits
    assign sum = {old[DATA_WIDTH-1], old} +
                 {delta_data[DATA_WIDTH-1], delta_data};
    assign ovf = sum[DATA_WIDTH] != sum[DATA_WIDTH-1];
    assign sum_sat = !ovf ? sum[DATA_WIDTH-1:0] :
                     sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                       {1'b0, {(DATA_WIDTH-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_ok) state_nx = RD;
            RD:      if (!mac_req) state_nx = CAP;
            CAP:     state_nx = DELTA;
            DELTA:   if (delta_valid) state_nx = last ? FIN : RD;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // MAC owns port A whenever it asks; the sweep only reads in RD
    always_comb begin
        bram_en_a   = 1'b0;
        bram_addr_a = '0;
        if (mac_req) begin
            bram_en_a   = 1'b1;
            bram_addr_a = mac_addr;
        end else if (state == RD) begin
            bram_en_a   = 1'b1;
            bram_addr_a = cur_addr;
        end
        upd_busy    = state != IDLE;
        upd_done    = state == FIN;
        delta_ready = state == DELTA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base         <= '0;
            idx          <= '0;
            old          <= '0;
            upd_sat      <= 1'b0;
            mac_rvalid   <= 1'b0;
            bram_en_b    <= 1'b0;
            bram_addr_b  <= '0;
            bram_wdata_b <= '0;
        end else begin
            mac_rvalid <= mac_req;
            bram_en_b  <= hs;
            if (state == IDLE && start_ok) begin
                base    <= ADDR_W'(upd_neuron) * ADDR_W'(INPUT_SIZE);
                idx     <= '0;
                upd_sat <= 1'b0;
            end
            if (state == CAP) old <= bram_rdata_a;
            if (hs) begin
                bram_addr_b  <= cur_addr;
                bram_wdata_b <= sum_sat;
                if (ovf)   upd_sat <= 1'b1;
                if (!last) idx <= idx + 1'b1;
            end
        end
    end

endmodule
